// File: rtl/matrix_skew_loader_pkg.sv
// Shared definitions for the matrix skew loader.
//   state_t  : loader FSM states (IDLE, LOAD, STREAM)
//   DEF_*    : default element width, lane count and row count
//   ELEM_W   : element counter width for the default geometry
//   SKEW_W   : skew counter width for the default geometry
//   cnt_w()  : counter width helper, never narrower than one bit
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_t;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_LANES = 4;
  localparam int unsigned DEF_ROWS  = 4;
  localparam int unsigned ELEM_W    = cnt_w(DEF_ROWS * DEF_LANES);
  localparam int unsigned SKEW_W    = cnt_w(DEF_ROWS + DEF_LANES - 1);

endpackage

// File: rtl/lane_skew_sel.sv
// One output lane of the skew loader. Picks row (s_cnt - K) of its matrix
// column while that row index is in range, otherwise drives zero/invalid.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_en         : skew step is active this cycle
//   i_s_cnt      : current skew step
//   i_col        : ROWS column elements, row r at [r*DW +: DW]
//   o_data       : registered lane element
//   o_valid      : registered lane valid
module lane_skew_sel #(
  parameter int unsigned DW   = 8,
  parameter int unsigned ROWS = 4,
  parameter int unsigned SW   = 3,
  parameter int unsigned K    = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [SW-1:0]      i_s_cnt,
  input  logic [ROWS*DW-1:0] i_col,
  output logic [DW-1:0]      o_data,
  output logic               o_valid
);

  // One extra bit so the row limit and lane offset never truncate.
  localparam logic [SW:0] K_V    = (SW+1)'(K);
  localparam logic [SW:0] ROWS_V = (SW+1)'(ROWS);

  logic [SW:0]   w_s;
  logic [SW:0]   w_d;
  logic          w_hit;
  logic [DW-1:0] w_sel;

  always_comb begin
    w_s   = {1'b0, i_s_cnt};
    w_d   = w_s - K_V;
    w_hit = i_en && (w_s >= K_V) && (w_d < ROWS_V);
    w_sel = '0;
    if (w_hit) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (w_d == (SW+1)'(r)) w_sel = i_col[r*DW +: DW];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_data  <= w_sel;
      o_valid <= w_hit;
    end
  end

endmodule

// File: rtl/matrix_skew_loader.sv
// Loads a ROWS x LANES matrix byte-serially (row-major, valid/ready) and
// replays it on LANES parallel lanes with diagonal skew: lane k lags lane 0
// by k cycles.
// Ports:
//   CLK, RST  : clock, synchronous active-high reset
//   start     : one-cycle request to begin loading (ignored while busy)
//   in_data   : matrix element, in_valid qualifies it
//   in_ready  : high throughout LOAD
//   out_data  : lane k at [k*DW +: DW]; out_valid : per-lane valid
//   busy      : FSM not idle; done : one-cycle pulse after the last element
module matrix_skew_loader
  import loader_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned ROWS  = DEF_ROWS
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [DW-1:0]       in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [LANES*DW-1:0] out_data,
  output logic [LANES-1:0]    out_valid,
  output logic                busy,
  output logic                done
);

  localparam int unsigned NELEM = ROWS * LANES;
  localparam int unsigned NSKEW = ROWS + LANES - 1;
  localparam int unsigned EW    = cnt_w(NELEM);
  localparam int unsigned SW    = cnt_w(NSKEW);
  localparam logic [EW-1:0] ELEM_LAST = EW'(NELEM - 1);
  localparam logic [SW-1:0] SKEW_LAST = SW'(NSKEW - 1);

  state_t        r_state;
  state_t        w_next;
  logic [EW-1:0] r_elem_cnt;
  logic [SW-1:0] r_s_cnt;
  logic          r_drain;
  logic          r_done;
  logic [DW-1:0] r_mat [NELEM];

  logic              w_accept;
  logic              w_last_byte;
  logic              w_stream_en;
  logic [ROWS*DW-1:0] w_col [LANES];

  assign w_accept    = in_valid && (r_state == LOAD);
  assign w_last_byte = w_accept && (r_elem_cnt == ELEM_LAST);
  // r_drain marks the extra cycle after the last skew step, which clears the
  // lanes and raises done one edge later than the final element.
  assign w_stream_en = (r_state == STREAM) && !r_drain;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    if (w_last_byte) w_next = STREAM;
      STREAM:  if (r_drain) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_elem_cnt <= '0;
      r_s_cnt    <= '0;
      r_drain    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_accept) r_elem_cnt <= w_last_byte ? '0 : r_elem_cnt + 1'b1;
      if (w_stream_en) r_s_cnt <= (r_s_cnt == SKEW_LAST) ? '0 : r_s_cnt + 1'b1;
      r_drain <= w_stream_en && (r_s_cnt == SKEW_LAST);
      r_done  <= (r_state == STREAM) && r_drain;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept) r_mat[r_elem_cnt] <= in_data;
  end

  always_comb begin
    w_col = '{default: '0};
    for (int unsigned k = 0; k < LANES; k++) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        w_col[k][r*DW +: DW] = r_mat[r*LANES + k];
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_skew_sel #(
      .DW  (DW),
      .ROWS(ROWS),
      .SW  (SW),
      .K   (k)
    ) u_sel (
      .i_clk  (CLK),
      .i_rst  (RST),
      .i_en   (w_stream_en),
      .i_s_cnt(r_s_cnt),
      .i_col  (w_col[k]),
      .o_data (out_data[k*DW +: DW]),
      .o_valid(out_valid[k])
    );
  end

  assign in_ready = (r_state == LOAD);
  assign busy     = (r_state != IDLE);
  assign done     = r_done;

endmodule

// File: tb/tb_matrix_skew_loader.sv
module tb_matrix_skew_loader;

  localparam int DW = 8;
  localparam int L  = 4;
  localparam int R  = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [L*DW-1:0] out_data;
  logic [L-1:0]  out_valid;
  logic          busy;
  logic          done;

  matrix_skew_loader #(.DW(DW), .LANES(L), .ROWS(R)) dut (
    .CLK(CLK), .RST(RST), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 loading, 2 streaming; t counts edges
  // since the final byte was accepted.
  int          m_phase = 0;
  int          m_n = 0;
  int          m_t = 0;
  logic [7:0]  m_mat [R][L];
  logic [L*DW-1:0] exp_data = '0;
  logic [L-1:0]    exp_valid = '0;
  logic        exp_ready = 1'b0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;

  always @(posedge CLK) begin
    exp_done = 1'b0;
    if (RST) begin
      m_phase = 0; m_n = 0; m_t = 0;
    end else begin
      case (m_phase)
        0: if (start) m_phase = 1;
        1: if (in_valid) begin
             m_mat[m_n / L][m_n % L] = in_data;
             m_n++;
             if (m_n == R * L) begin m_phase = 2; m_n = 0; m_t = 0; end
           end
        default: begin
          m_t++;
          if (m_t == R + L) begin m_phase = 0; exp_done = 1'b1; end
        end
      endcase
    end
    exp_data  = '0;
    exp_valid = '0;
    if (m_phase == 2 && m_t >= 1) begin
      for (int k = 0; k < L; k++) begin
        int d;
        d = (m_t - 1) - k;
        if (d >= 0 && d < R) begin
          exp_data[k*DW +: DW] = m_mat[d][k];
          exp_valid[k] = 1'b1;
        end
      end
    end
    exp_ready = (m_phase == 1);
    exp_busy  = (m_phase != 0);
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("in_ready",  64'(in_ready),  64'(exp_ready));
      check("out_data",  64'(out_data),  64'(exp_data));
      check("out_valid", 64'(out_valid), 64'(exp_valid));
      check("busy",      64'(busy),      64'(exp_busy));
      check("done",      64'(done),      64'(exp_done));
    end
  end

  int acc_cnt = 0;
  int rdy_cnt = 0;
  always @(negedge CLK) begin
    if (in_ready) rdy_cnt++;
    if (in_ready && in_valid) acc_cnt++;
  end

  logic [7:0] tx [R*L];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: one stall before every byte after the first,
  // 2: random stalls.
  task automatic send_n(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      if (mode == 1 && i > 0) begin
        in_valid = 1'b0; in_data = 8'($urandom); tick();
      end else if (mode == 2) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0; in_data = 8'($urandom); tick();
        end
      end
      in_valid = 1'b1;
      in_data  = tx[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic fill_seq(input int base);
    for (int i = 0; i < R * L; i++) tx[i] = 8'(base + i);
  endtask

  task automatic fill_rand;
    for (int i = 0; i < R * L; i++) tx[i] = 8'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    RST = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'hAA;

    // Reset with start/in_valid toggling
    tick();
    chk_en = 1'b1;
    start = 1'b0; in_valid = 1'b0;
    tick();
    start = 1'b1; in_valid = 1'b1;
    tick();
    RST = 1'b0; start = 1'b0; in_valid = 1'b0;
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    idle(2);

    // Nominal load and stream with hand-computed lane values
    fill_seq(1);
    do_start();
    send_n(R * L, 0);
    tick();
    check("s1_data", 64'(out_data), 64'h0000_0001);
    check("s1_valid", 64'(out_valid), 64'b0001);
    tick();
    check("s2_data", 64'(out_data), 64'h0000_0205);
    check("s2_valid", 64'(out_valid), 64'b0011);
    idle(2);
    check("s4_data", 64'(out_data), 64'h0407_0A0D);
    check("s4_valid", 64'(out_valid), 64'b1111);
    idle(3);
    check("s7_data", 64'(out_data), 64'h1000_0000);
    check("s7_valid", 64'(out_valid), 64'b1000);
    tick();
    check("s8_done", 64'(done), 64'h1);
    check("s8_valid", 64'(out_valid), 64'h0);
    idle(2);

    // Stalled input: 16 accepts over 31 ready cycles
    acc_cnt = 0; rdy_cnt = 0;
    do_start();
    send_n(R * L, 1);
    check("stall_accepts", 64'(acc_cnt), 64'd16);
    check("stall_ready_cycles", 64'(rdy_cnt), 64'd31);
    idle(R + L + 1);

    // Ignored start / in_valid while streaming
    fill_rand();
    do_start();
    send_n(R * L, 0);
    for (int i = 0; i < R + L; i++) begin
      start = 1'($urandom); in_valid = 1'b1; in_data = 8'($urandom);
      tick();
    end
    start = 1'b0; in_valid = 1'b0;
    idle(2);

    // Reset at byte 9 of LOAD
    fill_rand();
    do_start();
    send_n(8, 0);
    in_valid = 1'b1; in_data = 8'h55; RST = 1'b1;
    tick();
    RST = 1'b0; in_valid = 1'b0;
    check("rst_load_busy", 64'(busy), 64'h0);
    check("rst_load_ready", 64'(in_ready), 64'h0);
    idle(2);
    fill_rand();
    do_start();
    send_n(R * L, 0);
    idle(R + L + 1);

    // Reset at stream cycle 3
    fill_rand();
    do_start();
    send_n(R * L, 0);
    idle(3);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst_stream_busy", 64'(busy), 64'h0);
    check("rst_stream_valid", 64'(out_valid), 64'h0);
    idle(R + L + 2);
    fill_rand();
    do_start();
    send_n(R * L, 0);
    idle(R + L + 1);

    // Back-to-back: start in the done cycle
    fill_rand();
    do_start();
    send_n(R * L, 0);
    idle(R + L);
    check("b2b_done", 64'(done), 64'h1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_ready", 64'(in_ready), 64'h1);
    fill_seq(8'hF0);
    send_n(R * L, 0);
    idle(R + L + 1);

    // Randomized matrices, stalls, gaps and spurious controls
    for (int it = 0; it < 8; it++) begin
      fill_rand();
      idle($urandom_range(0, 3));
      do_start();
      send_n(R * L, 2);
      for (int i = 0; i < R + L; i++) begin
        start = 1'($urandom_range(0, 1)); in_valid = 1'($urandom_range(0, 1));
        in_data = 8'($urandom);
        tick();
      end
      start = 1'b0; in_valid = 1'b0;
      idle(1);
    end
    idle(3);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
